ahb_arbiter_rr: RTL and testbench
=================================

# ahb_arbiter_rr

Parametrised AHB bus arbiter for up to `NUM_MASTERS` masters with selectable round-robin or fixed-priority arbitration, locked-transfer support and split-masking. It sits between the masters' request/lock lines and the AHB address/data multiplexers. It drives one-hot grants, the current bus owner (`HMASTER`) and `HMASTLOCK`. It generalises the fixed 16-master arbiter by adding rotating fairness, a default master and split bookkeeping driven by `HRESP`.

## Interface
- `NUM_MASTERS`, default 16: number of masters, 2..16.
- `DEFAULT_MASTER`, default 0: master granted when nothing is eligible; reset owner.
- `ARB_MODE`, default `ARB_RR`: `ARB_RR` (round-robin) or `ARB_FIXED` (lowest index wins).
- `HCLK` in 1: single clock, all state on rising edge.
- `HRESETn` in 1: reset, synchronous and active-low.
- `HBUSREQx` in `NUM_MASTERS`: bus request per master.
- `HLOCKx` in `NUM_MASTERS`: locked-transfer request per master.
- `HSPLIT` in `NUM_MASTERS`: split-completion from slaves; bit i unmasks master i.
- `HREADY` in 1: transfer-complete; arbitration and ownership handover only when high.
- `HRESP` in 2: slave response; `2'b11` is SPLIT.
- `HGRANTx` out `NUM_MASTERS`: registered one-hot grant.
- `HMASTER` out `MW = $clog2(NUM_MASTERS)`: index of the address-phase owner.
- `HMASTLOCK` out 1: current address-phase transfer is locked.

## Operation
- Reset values:
  - `HGRANTx` = one-hot(`DEFAULT_MASTER`); `HMASTER` = `DEFAULT_MASTER`; `HMASTLOCK` = 0.
  - `split_mask` = 0; round-robin pointer `last` = `DEFAULT_MASTER`.
- Eligibility: `elig = HBUSREQx & ~split_mask`.
- Selection:
  - `ARB_FIXED`: lowest set index of `elig`.
  - `ARB_RR`: first set bit of `elig` searching `last+1, last+2, …`, wrapping modulo `NUM_MASTERS`.
  - `elig == 0`: grant `DEFAULT_MASTER`, even if requests are present but masked.
- State machine, states `DEFAULT`, `GRANTED`, `LOCKED`:
  - `DEFAULT` → `GRANTED` when the selection winner is a requesting master at an `HREADY` cycle.
  - `GRANTED` → `LOCKED` when the granted master asserts its `HLOCKx` bit.
  - `LOCKED` → `GRANTED`/`DEFAULT` only at an `HREADY` cycle where both the owner's `HLOCKx` and `HMASTLOCK` are low; this covers the trailing locked data phase.
  - `GRANTED` → `DEFAULT` when `elig` becomes 0 at an `HREADY` cycle.
- Re-arbitration:
  - Happens every `HREADY`=1 cycle outside `LOCKED`.
  - A master that keeps requesting while still the winner retains the grant.
- `last` updates to the new winner whenever a grant changes to a requesting master. It does not update on a default-master grant.
- Split handling:
  - `HRESP==2'b11` with `HREADY`=0 (first SPLIT cycle) sets `split_mask[HMASTER]`.
  - `HSPLIT[i]` clears `split_mask[i]`.
  - Same-cycle set and clear on one bit: set wins, i.e. `mask_next = (mask & ~HSPLIT) | set`.
- SPLIT overrides lock: a split of the locked owner forces exit from `LOCKED` at the next `HREADY`.
- `HSPLIT` bits at index ≥ `NUM_MASTERS` do not exist; no width truncation is needed.
- Invariants:
  - `$countones(HGRANTx)==1` always.
  - `HGRANTx[i]` is never set for an unrequesting `i` unless `i==DEFAULT_MASTER`.

## Timing
- Grant latency:
  - Request sampled at cycle n with `HREADY`=1 → `HGRANTx` updates at n+1.
  - While `HREADY`=0, `HGRANTx` holds.
- Ownership:
  - `HMASTER` and `HMASTLOCK` load from the grant index and the owner's `HLOCKx` at the next `HREADY`=1 edge after the grant changes.
  - `HMASTER` therefore lags `HGRANTx` by one completed transfer.
- `split_mask` affects arbitration the cycle after it is set.
- Reset mid-transfer or mid-lock: the next edge with `HRESETn`=0 restores all reset values, regardless of `HREADY` or state.

## Structure
- Package `ahb_arb_pkg`:
  - `arb_mode_e` {`ARB_RR`, `ARB_FIXED`}.
  - `hresp_e` {`OKAY`, `ERROR`, `RETRY`, `SPLIT`}.
  - `arb_state_e` {`DEFAULT`, `GRANTED`, `LOCKED`}.
- Sub-module `ahb_rr_picker`, combinational:
  - Inputs: request vector, pointer, mode.
  - Outputs: one-hot winner, index, valid.
  - Parametrised by `NUM_MASTERS`; reusable by other arbiters.
- Top module: FSM, `last`, `split_mask`, output registers.

## Test plan
- Reset, `NUM_MASTERS`=4, `DEFAULT_MASTER`=0, no requests → `HGRANTx`=4'b0001, `HMASTER`=0, `HMASTLOCK`=0.
- RR: `HBUSREQx`=4'b1111 held, `HREADY`=1, each master drops request after its grant → grant order 1,2,3,0,1.
- FIXED: `HBUSREQx`=4'b1010 → grant 1; then raise bit 0 → grant 0 the next `HREADY` cycle.
- Lock: master 2 granted with `HLOCKx[2]`=1, master 3 requesting → grant stays 2 until `HLOCKx[2]` and `HMASTLOCK` are both low, then 3.
- Split: owner 1 gets `HRESP`=SPLIT with `HREADY`=0 → `split_mask[1]`=1 and master 1 is not regranted despite requesting. `HSPLIT`=4'b0010 → master 1 is granted within `NUM_MASTERS` `HREADY` cycles.
- `HREADY`=0 held for 5 cycles with changing requests → `HGRANTx` and `HMASTER` stable. `HRESETn`=0 during `LOCKED` → reset values on the next edge.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared types for the AHB bus arbiter
package ahb_arb_pkg;

  // Arbitration policy selected at elaboration time
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // AHB slave response encoding
  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_e;

  // Arbiter ownership state
  typedef enum logic [1:0] {
    DEFAULT = 2'b00,
    GRANTED = 2'b01,
    LOCKED  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin / fixed-priority winner picker
module ahb_rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int  NUM_MASTERS = 16,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [MW-1:0]          ptr_i,
  input  arb_mode_e              mode_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [MW-1:0]          idx_o,
  output logic                   valid_o
);

  // Scan candidates in priority order: ptr+1, ptr+2, ... (RR) or 0, 1, ... (fixed)
  always_comb begin
    int            cand;
    logic [MW-1:0] cand_idx;
    logic          found;
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (mode_i == ARB_FIXED) begin
        cand = k;
      end else begin
        cand = (int'(ptr_i) + 1 + k) % NUM_MASTERS;
      end
      cand_idx = cand[MW-1:0];
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        valid_o           = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// rtl/ahb_arbiter_rr.sv - AHB arbiter with round-robin/fixed policy, locking and split masking
module ahb_arbiter_rr
  import ahb_arb_pkg::*;
#(
  parameter int        NUM_MASTERS    = 16,
  parameter int        DEFAULT_MASTER = 0,
  parameter arb_mode_e ARB_MODE       = ARB_RR,
  localparam int       MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          gidx_q, gidx_d;
  logic [MW-1:0]          last_q, last_d;
  logic [MW-1:0]          master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [MW-1:0]          win_idx;
  logic                   win_valid;
  logic                   rearb;
  logic [NUM_MASTERS-1:0] split_set;

  // Masters parked by a SPLIT response are invisible to arbitration
  assign elig = HBUSREQx & ~mask_q;

  ahb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req_i   (elig),
    .ptr_i   (last_q),
    .mode_i  (ARB_MODE),
    .grant_o (win_oh),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Split bookkeeping: first SPLIT cycle parks HMASTER, HSPLIT releases; set beats clear
  always_comb begin
    split_set = '0;
    if ((HRESP == SPLIT) && !HREADY) begin
      split_set[master_q] = 1'b1;
    end
    mask_d = (mask_q & ~HSPLIT) | split_set;
  end

  // Next-state and grant decision; a locked owner holds the bus until lock and trailing phase end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    rearb   = 1'b0;
    case (state_q)
      DEFAULT: rearb = HREADY;
      GRANTED: begin
        if (HLOCKx[gidx_q] && !mask_q[gidx_q]) begin
          state_d = LOCKED;
        end else begin
          rearb = HREADY;
        end
      end
      LOCKED: begin
        // A split owner cannot keep the bus locked while it is parked
        if (HREADY && ((!HLOCKx[gidx_q] && !mastlock_q) || mask_q[gidx_q])) begin
          rearb = 1'b1;
        end
      end
      default: begin
        state_d = DEFAULT;
        rearb   = HREADY;
      end
    endcase
    if (rearb) begin
      if (win_valid) begin
        state_d = GRANTED;
        grant_d = win_oh;
        gidx_d  = win_idx;
        if (win_oh != grant_q) begin
          last_d = win_idx;
        end
      end else begin
        state_d = DEFAULT;
        grant_d = DEF_OH;
        gidx_d  = DEF_IDX;
      end
    end
  end

  // Address-phase ownership follows the grant at each completed transfer
  always_comb begin
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (HREADY) begin
      master_d   = gidx_q;
      mastlock_d = HLOCKx[gidx_q];
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= DEFAULT;
      grant_q    <= DEF_OH;
      gidx_q     <= DEF_IDX;
      last_q     <= DEF_IDX;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      mask_q     <= mask_d;
    end
  end

  assign HGRANTx   = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// tb/tb_ahb_arbiter_rr.sv - scoreboard testbench for ahb_arbiter_rr
module tb_ahb_arbiter_rr;
  import ahb_arb_pkg::*;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] split;
    logic       ready;
    logic [1:0] resp;
    logic [3:0] grant;
    logic [1:0] master;
    logic       mlock;
    logic [3:0] mask;
  } row_t;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] HBUSREQx;
  logic [3:0] HLOCKx;
  logic [3:0] HSPLIT;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] g_rr, g_fx;
  logic [1:0] m_rr, m_fx;
  logic       l_rr, l_fx;

  int   checks   = 0;
  int   failures = 0;
  row_t sb[$];

  ahb_arbiter_rr #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(ARB_RR)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANTx(g_rr), .HMASTER(m_rr), .HMASTLOCK(l_rr)
  );

  ahb_arbiter_rr #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(ARB_FIXED)) dut_fx (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANTx(g_fx), .HMASTER(m_fx), .HMASTLOCK(l_fx)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic row_t mk(logic rstn, logic [3:0] req, logic [3:0] lock, logic [3:0] split,
                              logic ready, logic [1:0] resp, logic [3:0] grant,
                              logic [1:0] master, logic mlock, logic [3:0] mask);
    row_t r;
    r.rstn = rstn; r.req = req; r.lock = lock; r.split = split; r.ready = ready;
    r.resp = resp; r.grant = grant; r.master = master; r.mlock = mlock; r.mask = mask;
    return r;
  endfunction

  task automatic drive(row_t r);
    HRESETn  = r.rstn;
    HBUSREQx = r.req;
    HLOCKx   = r.lock;
    HSPLIT   = r.split;
    HREADY   = r.ready;
    HRESP    = r.resp;
  endtask

  task automatic do_reset();
    drive(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0, 4'b0000));
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'b11, 4'b0001, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0001, 2'd0, 1'b0, 4'b0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_rr !== e.grant || m_rr !== e.master || l_rr !== e.mlock) begin
        failures++;
        $display("FAIL reset_rr[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_rr, m_rr, l_rr, e.grant, e.master, e.mlock);
      end
      checks++;
      if (g_fx !== e.grant || m_fx !== e.master || l_fx !== e.mlock) begin
        failures++;
        $display("FAIL reset_fx[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_fx, m_fx, l_fx, e.grant, e.master, e.mlock);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1101, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd1, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b1000, 2'd2, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0111, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0001, 2'd3, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_rr !== e.grant || m_rr !== e.master || l_rr !== e.mlock) begin
        failures++;
        $display("FAIL rr[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_rr, m_rr, l_rr, e.grant, e.master, e.mlock);
      end
    end
  endtask

  task automatic test_fixed();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0001, 2'd1, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_fx !== e.grant || m_fx !== e.master || l_fx !== e.mlock) begin
        failures++;
        $display("FAIL fixed[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_fx, m_fx, l_fx, e.grant, e.master, e.mlock);
      end
    end
  endtask

  task automatic test_lock();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1100, 4'b0100, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b1, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1100, 4'b0100, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b1, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1100, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1100, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b1000, 2'd2, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b1000, 2'd3, 1'b0, 4'b0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_rr !== e.grant || m_rr !== e.master || l_rr !== e.mlock) begin
        failures++;
        $display("FAIL lock[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_rr, m_rr, l_rr, e.grant, e.master, e.mlock);
      end
    end
  endtask

  task automatic test_split();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd1, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 2'b11, 4'b0010, 2'd1, 1'b0, 4'b0010));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b1, 2'b11, 4'b0100, 2'd1, 1'b0, 4'b0010));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b0, 4'b0010));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0001, 2'd2, 1'b0, 4'b0010));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd1, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'b11, 4'b0010, 2'd1, 1'b0, 4'b0010));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'b11, 4'b0001, 2'd1, 1'b0, 4'b0010));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_rr !== e.grant || m_rr !== e.master || l_rr !== e.mlock) begin
        failures++;
        $display("FAIL split[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_rr, m_rr, l_rr, e.grant, e.master, e.mlock);
      end
      checks++;
      if (dut_rr.mask_q !== e.mask) begin
        failures++;
        $display("FAIL split_mask[%0d]: got %b, want %b", i, dut_rr.mask_q, e.mask);
      end
    end
  endtask

  task automatic test_split_lock();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(1'b1, 4'b0110, 4'b0010, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0010, 4'b0000, 1'b1, 2'b00, 4'b0010, 2'd1, 1'b1, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0010, 4'b0000, 1'b0, 2'b11, 4'b0010, 2'd1, 1'b1, 4'b0010));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0010, 4'b0000, 1'b1, 2'b11, 4'b0100, 2'd1, 1'b1, 4'b0010));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b0, 4'b0010));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_rr !== e.grant || m_rr !== e.master || l_rr !== e.mlock) begin
        failures++;
        $display("FAIL split_lock[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_rr, m_rr, l_rr, e.grant, e.master, e.mlock);
      end
    end
  endtask

  task automatic test_hready_hold();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b1000, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b1000, 2'd3, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b1000, 2'd3, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b1000, 2'd3, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b1000, 2'd3, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b1000, 2'd3, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b1000, 2'd3, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0001, 2'd3, 1'b0, 4'b0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_rr !== e.grant || m_rr !== e.master || l_rr !== e.mlock) begin
        failures++;
        $display("FAIL hready_hold[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_rr, m_rr, l_rr, e.grant, e.master, e.mlock);
      end
    end
  endtask

  task automatic test_reset_locked();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b1, 4'b0000));
    rows.push_back(mk(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0001, 2'd0, 1'b0, 4'b0000));
    rows.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0, 4'b0000));
    foreach (rows[i]) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      @(posedge HCLK);
      #1;
      e = sb.pop_front();
      checks++;
      if (g_rr !== e.grant || m_rr !== e.master || l_rr !== e.mlock) begin
        failures++;
        $display("FAIL reset_locked[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 i, g_rr, m_rr, l_rr, e.grant, e.master, e.mlock);
      end
    end
  endtask

  initial begin
    HRESETn  = 1'b0;
    HBUSREQx = 4'b0000;
    HLOCKx   = 4'b0000;
    HSPLIT   = 4'b0000;
    HREADY   = 1'b1;
    HRESP    = 2'b00;
    #1;
    test_reset();
    test_round_robin();
    test_fixed();
    test_lock();
    test_split();
    test_split_lock();
    test_hready_hold();
    test_reset_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
